// File: rtl/cc_clk_div_multi.sv
// N-channel phase-accumulator clock divider producing per-channel ICG enables.
// Increment changes are shadowed and only applied at a phase wrap, so output periods never glitch.
module cc_clk_div_multi #(
    parameter int   N_CH     = 4,
    parameter int   ACC_W    = 16,
    parameter logic DIS_PASS = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_CH*ACC_W-1:0]  incr,
    input  logic [N_CH-1:0]        enable,
    input  logic [N_CH-1:0]        clear,
    output logic [N_CH-1:0]        cg_en,
    output logic [N_CH-1:0]        upd_pending
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [ACC_W-1:0] incr_req;
        logic [ACC_W-1:0] acc_q, acc_d;
        logic [ACC_W-1:0] act_q, act_d;
        logic [ACC_W:0]   sum;
        logic             carry;
        logic             cg_q, cg_d;
        logic             upd_q, upd_d;

        assign incr_req = incr[g*ACC_W +: ACC_W];
        assign sum      = {1'b0, acc_q} + {1'b0, act_q};
        assign carry    = sum[ACC_W];

        always_comb begin
            acc_d = acc_q;
            act_d = act_q;
            cg_d  = cg_q;
            if (clear[g]) begin
                // A clear swallows any carry due on this edge.
                acc_d = '0;
                act_d = incr_req;
                cg_d  = enable[g] ? 1'b0 : DIS_PASS;
            end else if (!enable[g]) begin
                acc_d = '0;
                act_d = incr_req;
                cg_d  = DIS_PASS;
            end else begin
                acc_d = sum[ACC_W-1:0];
                cg_d  = carry;
                if (carry) begin
                    act_d = incr_req;
                end
            end
            upd_d = enable[g] & ~clear[g] & (incr_req != act_d);
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                acc_q <= '0;
                act_q <= '0;
                cg_q  <= 1'b0;
                upd_q <= 1'b0;
            end else begin
                acc_q <= acc_d;
                act_q <= act_d;
                cg_q  <= cg_d;
                upd_q <= upd_d;
            end
        end

        assign cg_en[g]       = cg_q;
        assign upd_pending[g] = upd_q;
    end

endmodule

// File: tb/tb_cc_clk_div_multi.sv
// Randomised and directed bench for cc_clk_div_multi with an arithmetic phase model,
// driving one DIS_PASS=1 and one DIS_PASS=0 instance from the same stimulus.
module tb_cc_clk_div_multi;
    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N*W-1:0] incr = '0;
    logic [N-1:0]   enable = '0;
    logic [N-1:0]   clear = '0;
    logic [N-1:0]   cg1, up1, cg0, up0;

    int  errors = 0;
    int  checks = 0;
    bit  chk_on = 1'b0;
    int  pulses = 0;

    always #5 clk = ~clk;

    cc_clk_div_multi #(.N_CH(N), .ACC_W(W), .DIS_PASS(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .incr(incr), .enable(enable), .clear(clear),
        .cg_en(cg1), .upd_pending(up1));

    cc_clk_div_multi #(.N_CH(N), .ACC_W(W), .DIS_PASS(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .incr(incr), .enable(enable), .clear(clear),
        .cg_en(cg0), .upd_pending(up0));

    // Behavioural model: index 0 models DIS_PASS=1, index 1 models DIS_PASS=0.
    int m_acc [2][N];
    int m_act [2][N];
    bit m_cg  [2][N];
    bit m_up  [2][N];

    always @(posedge clk or negedge reset_n) begin
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) begin
                automatic int inc  = int'(incr[c*W +: W]);
                automatic int s    = m_acc[d][c] + m_act[d][c];
                automatic bit dis  = (d == 0);
                automatic bit wrap = (s >= (1 << W));
                automatic int nact = m_act[d][c];
                if (!reset_n) begin
                    m_acc[d][c] <= 0;
                    m_act[d][c] <= 0;
                    m_cg[d][c]  <= 1'b0;
                    m_up[d][c]  <= 1'b0;
                end else begin
                    if (clear[c]) begin
                        nact = inc;
                        m_acc[d][c] <= 0;
                        m_cg[d][c]  <= enable[c] ? 1'b0 : dis;
                    end else if (!enable[c]) begin
                        nact = inc;
                        m_acc[d][c] <= 0;
                        m_cg[d][c]  <= dis;
                    end else begin
                        if (wrap) nact = inc;
                        m_acc[d][c] <= s % (1 << W);
                        m_cg[d][c]  <= wrap;
                    end
                    m_act[d][c] <= nact;
                    m_up[d][c]  <= enable[c] && !clear[c] && (inc != nact);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                automatic logic [N-1:0] ecg = '0;
                automatic logic [N-1:0] eup = '0;
                for (int c = 0; c < N; c++) begin
                    ecg[c] = m_cg[d][c];
                    eup[c] = m_up[d][c];
                end
                check($sformatf("model cg_en dis%0d", 1 - d), {28'd0, (d == 0) ? cg1 : cg0}, {28'd0, ecg});
                check($sformatf("model upd_pending dis%0d", 1 - d), {28'd0, (d == 0) ? up1 : up0}, {28'd0, eup});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int exp_up [6];
        int exp_cg [6];
        exp_up = '{1, 1, 0, 0, 0, 0};
        exp_cg = '{0, 0, 1, 0, 1, 0};

        tick(2);
        reset_n = 1'b1;
        chk_on  = 1'b1;
        check("reset cg_en", {28'd0, cg1}, 32'd0);
        check("reset upd_pending", {28'd0, up1}, 32'd0);
        incr = {4'd3, 4'd8, 4'd5, 4'd4};
        tick(1);
        check("disabled cg_en pass", {28'd0, cg1}, 32'hF);
        check("disabled cg_en gated", {28'd0, cg0}, 32'h0);

        // ch0 period 4, ch1 incr 5 pulse count
        enable[1:0] = 2'b11;
        for (int k = 0; k < 32; k++) begin
            tick(1);
            if (k < 8) check($sformatf("ch0 pattern edge%0d", k + 1), {31'd0, cg1[0]}, (k % 4 == 3) ? 32'd1 : 32'd0);
            pulses += int'(cg1[1]);
        end
        check("ch1 pulses in 32", pulses, 32'd10);

        // incr change shortly after a wrap
        tick(1);
        incr[3:0] = 4'd8;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check($sformatf("upd ch0 k%0d", k), {31'd0, up1[0]}, exp_up[k]);
            check($sformatf("cg ch0 k%0d", k), {31'd0, cg1[0]}, exp_cg[k]);
        end

        // clear on the carry-due edge
        enable[2] = 1'b1;
        tick(1);
        check("ch2 first edge", {31'd0, cg1[2]}, 32'd0);
        clear[2] = 1'b1;
        tick(1);
        check("ch2 clear suppresses", {31'd0, cg1[2]}, 32'd0);
        clear[2] = 1'b0;
        tick(1);
        check("ch2 after clear +1", {31'd0, cg1[2]}, 32'd0);
        tick(1);
        check("ch2 after clear +2", {31'd0, cg1[2]}, 32'd1);

        // disable with both disabled-output levels
        enable[3] = 1'b1;
        tick(3);
        enable[3] = 1'b0;
        tick(1);
        check("ch3 disabled pass", {31'd0, cg1[3]}, 32'd1);
        check("ch3 disabled upd", {31'd0, up1[3]}, 32'd0);
        check("ch3 disabled gated", {31'd0, cg0[3]}, 32'd0);

        // mid-cycle async reset
        enable = 4'hF;
        tick(5);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async reset cg_en", {24'd0, cg1, cg0}, 32'd0);
        check("async reset upd", {24'd0, up1, up0}, 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        check("post-reset stuck cg_en", {28'd0, cg1}, 32'd0);
        check("post-reset upd_pending", {28'd0, up1}, 32'hF);
        clear = 4'hF;
        tick(1);
        clear = 4'h0;
        check("post-clear cg_en", {28'd0, cg1}, 32'd0);

        // randomized traffic
        for (int it = 0; it < 800; it++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 99) < 15) begin
                    case ($urandom_range(0, 9))
                        0:       incr[c*W +: W] = 4'd0;
                        1:       incr[c*W +: W] = 4'd15;
                        default: incr[c*W +: W] = 4'($urandom_range(1, 15));
                    endcase
                end
                if ($urandom_range(0, 39) == 0) enable[c] = ~enable[c];
                clear[c] = ($urandom_range(0, 29) == 0);
            end
            if (it == 400) begin
                @(posedge clk);
                #3 reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
            tick(1);
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
